lpc_decode: RTL and testbench
=============================

// Module: lpc_decode
// PURPOSE
//  LPC synthesis (decoder) engine; inverse of the encode path. Accepts one frame of
//  16-bit residue e[n] and P fixed-point predictor coefficients, then rebuilds audio
//  y[n] = sat16(e[n] + sum_{k=1..P} a[k]*y[n-k]) with one serial MAC.
//  The rebuilt frame is held in an internal buffer and read back over a random-access port.
// PARAMETERS
//  N       160  samples per frame (N <= 256, addresses are 8 bit)
//  P       10   predictor order (number of coefficient registers)
//  A_FRAC  28   fractional bits of a[k] (signed Q3.28)
//  ACC_W   52   accumulator width (signed)
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  reset          in   1   synchronous, active-low (0 = reset)
//  start          in   1   one-cycle pulse: decode current frame
//  rready         out  1   1 = idle, results valid, inputs writable
//  residue_wen    in   1   residue write enable
//  residue_waddr  in   8   residue write address, 0..N-1
//  residue_din    in   16  residue sample, signed
//  a_wsel         in   P   one-hot coefficient write select; bit k-1 writes a[k]
//  a_din          in   32  coefficient value, signed Q3.28
//  y_raddr        in   8   output buffer read address
//  y_dout         out  16  y[y_raddr], combinational read, signed
// BEHAVIOUR
//  - Reset (reset==0 on a clock edge): state IDLE, rready=1, residue/a/y buffers,
//    history and accumulator cleared to 0; y_dout therefore reads 0. Reset wins over
//    every other input, including mid-decode; the partially decoded frame is discarded.
//  - States: IDLE, MAC, WB. rready=1 only in IDLE.
//  - IDLE: residue/a writes accepted (residue_waddr >= N ignored; multi-hot a_wsel writes
//    every selected reg). start -> MAC with n=0, k=1, acc = sext(e[0]) << A_FRAC.
//  - MAC (P cycles, k=1..P): acc += a[k]*y[n-k] (32x16 signed -> 48-bit product, sign-
//    extended to ACC_W). For n-k<0 the operand is history h[k-n-1] (see CONFIGURATION).
//    k==P -> WB.
//  - WB (1 cycle): y[n] = sat16(acc >>> A_FRAC) (arithmetic shift, floor; clamp to
//    [-32768, 32767]). n==N-1 -> IDLE; else n++, k=1, acc = sext(e[n+1]) << A_FRAC -> MAC.
//  - Latency: rready falls the cycle after start is sampled and rises exactly N*(P+1)
//    cycles after that edge (1760 at defaults). y[n] is readable the cycle after its WB.
//  - While busy: start, residue_wen, a_wsel ignored (no queuing). Simultaneous write and
//    start in IDLE: the write lands and start uses the pre-write value.
//  - y_raddr >= N returns 0. Inputs are not consumed: repeated start re-decodes the same frame.
// CONFIGURATION
//  LPC_DECODE_CARRY_EN defined: at end of each frame the last P outputs are saved as
//   history h[j]=y[N-1-j] and supply y[n-k] for n-k<0 in the next frame (continuous
//   filter state across frames; cleared only by reset).
//  Undefined: history is always 0; every frame starts from zero filter state; no
//   history registers are built.
// TESTING
//  1 all a=0, e[n]=n-80, start -> y[n]=n-80 for all n; rready high 1760 cycles after start.
//  2 a[1]=0x10000000 (1.0), others 0, e[0]=100, rest 0 -> y[n]=100 for all n.
//  3 a[1]=1.0, e[n]=1000 all n -> y[n]=1000*(n+1) until n=32, then y[n]=32767 (saturated).
//  4 a[1]=0xF8000000 (-0.5), e[0]=1000, rest 0 -> y=1000,-500,250,-125,62,-31,15,-8,4,-2,1,-1,...
//  5 a[1]=1.0, frame1 e[0]=300 rest 0; frame2 all e=0 -> with LPC_DECODE_CARRY_EN frame2
//    y[n]=300; without, frame2 y[n]=0.
//  6 reset=0 for one cycle 500 cycles into a decode -> next cycle rready=1, y_dout=0 at
//    any address; writes during busy never change results of a following decode.

Source files
------------

// File: rtl/lpc_decode.sv
// LPC synthesis filter: rebuilds y[n] = sat16(e[n] + sum a[k]*y[n-k]) with one serial MAC.
// Latency: N*(P+1) cycles from start to rready; y[n] readable the cycle after its write-back.
// Backpressure: start/residue/coefficient writes ignored while rready=0. Optional LPC_DECODE_CARRY_EN.
module lpc_decode #(
    parameter int N      = 160,
    parameter int P      = 10,
    parameter int A_FRAC = 28,
    parameter int ACC_W  = 52
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          rready,
    input  logic          residue_wen,
    input  logic [7:0]    residue_waddr,
    input  logic [15:0]   residue_din,
    input  logic [P-1:0]  a_wsel,
    input  logic [31:0]   a_din,
    input  logic [7:0]    y_raddr,
    output logic [15:0]   y_dout
);
    localparam int              KW     = $clog2(P + 1);
    localparam logic [7:0]      N_LAST = 8'(N - 1);
    localparam logic [KW-1:0]   K_LAST = KW'(P);

    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;
    state_t state, state_nxt;

    logic [15:0]              res_buf [N];
    logic [31:0]              a_reg   [P];
    logic [15:0]              y_buf   [N];
    logic [7:0]               n;
    logic [KW-1:0]            k;
    logic signed [ACC_W-1:0]  acc;

`ifdef LPC_DECODE_CARRY_EN
    logic [15:0]              hist [P];
    logic [KW-1:0]            hidx;
`endif

    logic [7:0]               k8;
    logic [15:0]              y_op;
    logic [31:0]              a_cur;
    logic signed [47:0]       prod;
    logic [15:0]              e_sel;
    logic signed [ACC_W-1:0]  e_acc;
    logic signed [ACC_W-1:0]  sh;
    logic [15:0]              y_sat;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (k == K_LAST) state_nxt = WB;
            WB:      state_nxt = (n == N_LAST) ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand y[n-k]; negative indices reach into the previous frame's tail (or zero).
    always_comb begin
        k8   = 8'(k);
        y_op = '0;
`ifdef LPC_DECODE_CARRY_EN
        hidx = KW'(k8 - n - 8'd1);
`endif
        if (n >= k8) y_op = y_buf[n - k8];
`ifdef LPC_DECODE_CARRY_EN
        else         y_op = hist[hidx];
`endif
        a_cur = a_reg[k - KW'(1)];
        prod  = {{16{a_cur[31]}}, a_cur} * {{32{y_op[15]}}, y_op};
        e_sel = (state == IDLE) ? res_buf[0] : res_buf[n + 8'd1];
        e_acc = {{(ACC_W-16){e_sel[15]}}, e_sel} << A_FRAC;
        sh    = acc >>> A_FRAC;
        if (!sh[ACC_W-1] && (|sh[ACC_W-2:15]))        y_sat = 16'h7FFF;
        else if (sh[ACC_W-1] && !(&sh[ACC_W-2:15]))   y_sat = 16'h8000;
        else                                          y_sat = sh[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                res_buf[i] <= '0;
                y_buf[i]   <= '0;
            end
            for (int i = 0; i < P; i++) a_reg[i] <= '0;
`ifdef LPC_DECODE_CARRY_EN
            for (int i = 0; i < P; i++) hist[i] <= '0;
`endif
            n   <= '0;
            k   <= KW'(1);
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (residue_wen && residue_waddr <= N_LAST) res_buf[residue_waddr] <= residue_din;
                    for (int i = 0; i < P; i++)
                        if (a_wsel[i]) a_reg[i] <= a_din;
                    if (start) begin
                        n   <= '0;
                        k   <= KW'(1);
                        acc <= e_acc;
                    end
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-48){prod[47]}}, prod};
                    if (k != K_LAST) k <= k + KW'(1);
                end
                WB: begin
                    y_buf[n] <= y_sat;
                    if (n == N_LAST) begin
`ifdef LPC_DECODE_CARRY_EN
                        for (int j = 0; j < P; j++)
                            hist[j] <= (j == 0) ? y_sat : y_buf[N-1-j];
`endif
                    end else begin
                        n   <= n + 8'd1;
                        k   <= KW'(1);
                        acc <= e_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rready = (state == IDLE);
    assign y_dout = (y_raddr <= N_LAST) ? y_buf[y_raddr] : 16'h0000;

endmodule

// File: tb/tb_lpc_decode.sv
// Scoreboard bench for lpc_decode: reference filter pushes expected y[n], readback pops and compares.
module tb_lpc_decode;
    localparam int N = 160;
    localparam int P = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          rready;
    logic          residue_wen = 1'b0;
    logic [7:0]    residue_waddr = '0;
    logic [15:0]   residue_din = '0;
    logic [P-1:0]  a_wsel = '0;
    logic [31:0]   a_din = '0;
    logic [7:0]    y_raddr = '0;
    logic [15:0]   y_dout;

    lpc_decode dut (
        .clk(clk), .reset(reset), .start(start), .rready(rready),
        .residue_wen(residue_wen), .residue_waddr(residue_waddr), .residue_din(residue_din),
        .a_wsel(a_wsel), .a_din(a_din), .y_raddr(y_raddr), .y_dout(y_dout)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    int     q[$];
    int     e_m[N];
    longint a_m[P];
    int     y_m[N];
    int     h_m[P];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_res(input int addr, input int val);
        residue_wen   = 1'b1;
        residue_waddr = 8'(addr);
        residue_din   = 16'(val);
        if (addr < N) e_m[addr] = val;
        tick();
        residue_wen = 1'b0;
    endtask

    task automatic wr_a(input logic [P-1:0] sel, input logic [31:0] val);
        a_wsel = sel;
        a_din  = val;
        for (int i = 0; i < P; i++)
            if (sel[i]) a_m[i] = longint'($signed(val));
        tick();
        a_wsel = '0;
    endtask

    task automatic fill_res(input int val);
        for (int i = 0; i < N; i++) wr_res(i, val);
    endtask

    task automatic model_frame();
        longint acc;
        int yv;
        for (int n = 0; n < N; n++) begin
            acc = longint'(e_m[n]) * 64'sd268435456;
            for (int k = 1; k <= P; k++) begin
                yv = 0;
                if (n - k >= 0) yv = y_m[n-k];
`ifdef LPC_DECODE_CARRY_EN
                else            yv = h_m[k-n-1];
`endif
                acc += a_m[k-1] * longint'(yv);
            end
            acc = acc >>> 28;
            if (acc > 32767)       acc = 32767;
            else if (acc < -32768) acc = -32768;
            y_m[n] = int'(acc);
            q.push_back(y_m[n]);
        end
`ifdef LPC_DECODE_CARRY_EN
        for (int j = 0; j < P; j++) h_m[j] = y_m[N-1-j];
`endif
    endtask

    task automatic rd_chk(input string tag, input int addr, input int exp);
        y_raddr = 8'(addr);
        #1;
        chk(tag, int'($signed(y_dout)), exp);
    endtask

    task automatic run_decode(input string tag, input bit busy_wr, input bit wr_at_start);
        int cnt;
        model_frame();
        start = 1'b1;
        if (wr_at_start) begin
            residue_wen   = 1'b1;
            residue_waddr = 8'd0;
            residue_din   = 16'd7;
        end
        tick();
        start = 1'b0;
        residue_wen = 1'b0;
        if (wr_at_start) e_m[0] = 7;
        chk({tag, "_busy"}, int'(rready), 0);
        cnt = 0;
        while (!rready && cnt < 3000) begin
            if (busy_wr && cnt < 10) begin
                residue_wen   = 1'b1;
                residue_waddr = 8'd0;
                residue_din   = 16'd12345;
                a_wsel        = '1;
                a_din         = 32'h7FFF_FFFF;
                start         = 1'b1;
            end else begin
                residue_wen = 1'b0;
                a_wsel      = '0;
                start       = 1'b0;
            end
            tick();
            cnt++;
        end
        residue_wen = 1'b0;
        a_wsel      = '0;
        start       = 1'b0;
        chk({tag, "_lat"}, cnt, 1760);
        for (int n = 0; n < N; n++) begin
            if (q.size() == 0) chk({tag, "_qempty"}, 1, 0);
            else               rd_chk({tag, "_y"}, n, q.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin e_m[i] = 0; y_m[i] = 0; end
        for (int i = 0; i < P; i++) begin a_m[i] = 0; h_m[i] = 0; end

        tick(); tick();
        reset = 1'b1;
        chk("rst_rready", int'(rready), 1);
        rd_chk("rst_y0", 0, 0);
        rd_chk("rst_y_oob", 200, 0);

        // Pure pass-through: no prediction.
        for (int i = 0; i < N; i++) wr_res(i, i - 80);
        wr_res(200, 555);
        run_decode("t1", 1'b0, 1'b0);
        rd_chk("t1_y0", 0, -80);
        rd_chk("t1_y159", 159, 79);

        fill_res(0);
        wr_a(10'h001, 32'h1000_0000);
        wr_res(0, 100);
        run_decode("t2", 1'b0, 1'b0);
        rd_chk("t2_y159", 159, 100);

        fill_res(1000);
        run_decode("t3", 1'b0, 1'b0);
        rd_chk("t3_y31", 31, 32000);
        rd_chk("t3_y32", 32, 32767);
        rd_chk("t3_oob", 255, 0);

        fill_res(0);
        wr_a(10'h001, 32'hF800_0000);
        wr_res(0, 1000);
        run_decode("t4", 1'b0, 1'b0);
        rd_chk("t4_y4", 4, 62);
        rd_chk("t4_y7", 7, -8);
        rd_chk("t4_y11", 11, -1);

        wr_a(10'h001, 32'h1000_0000);
        wr_res(0, 300);
        run_decode("t5a", 1'b0, 1'b0);
        wr_res(0, 0);
        run_decode("t5b", 1'b0, 1'b0);
`ifdef LPC_DECODE_CARRY_EN
        rd_chk("t5_carry", 50, 300);
`else
        rd_chk("t5_carry", 50, 0);
`endif

        // Multi-hot coefficient write plus random residue.
        wr_a('1, 32'h0);
        wr_a(10'h003, 32'h0400_0000);
        for (int i = 0; i < N; i++) wr_res(i, int'($urandom_range(4000)) - 2000);
        run_decode("t7", 1'b0, 1'b0);

        // Reset mid-decode discards everything.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (500) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_rready", int'(rready), 1);
        rd_chk("t6_y0", 0, 0);
        rd_chk("t6_y17", 17, 0);
        rd_chk("t6_y159", 159, 0);
        for (int i = 0; i < N; i++) begin e_m[i] = 0; y_m[i] = 0; end
        for (int i = 0; i < P; i++) begin a_m[i] = 0; h_m[i] = 0; end

        wr_a(10'h001, 32'h1000_0000);
        wr_res(0, 100);
        run_decode("t6a", 1'b1, 1'b1);
        run_decode("t6b", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
